// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one synchronous memory port between the CPU
// and a DMA master, with CPU priority bounded by a starvation counter.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [1:0]        dma_size,
  input  logic              dma_sign,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              memRDEN2,
  output logic              memWE2,
  output logic [ADDR_W-1:0] memADDR2,
  output logic [DATA_W-1:0] memDIN2,
  output logic [1:0]        memSize,
  output logic              memSign,
  input  logic [DATA_W-1:0] memDOUT2
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_CPU  = 2'b01,
    WIN_DMA  = 2'b10
  } win_e;

  win_e             win_s;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       rd_pend_q, rd_pend_d;

  // Pick this cycle's owner of the memory port.
  always_comb begin
    win_s = WIN_NONE;
    if (RST) begin
      win_s = WIN_NONE;
    end else if (cpu_req && dma_req) begin
      win_s = (starve_cnt_q == CNT_MAX) ? WIN_DMA : WIN_CPU;
    end else if (cpu_req) begin
      win_s = WIN_CPU;
    end else if (dma_req) begin
      win_s = WIN_DMA;
    end else begin
      win_s = WIN_NONE;
    end
  end

  // Route the winner onto the memory port; everything idles at zero otherwise.
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    memRDEN2 = 1'b0;
    memWE2   = 1'b0;
    memADDR2 = '0;
    memDIN2  = '0;
    memSize  = 2'b00;
    memSign  = 1'b0;
    case (win_s)
      WIN_CPU: begin
        cpu_gnt  = 1'b1;
        memRDEN2 = ~cpu_we;
        memWE2   = cpu_we;
        memADDR2 = cpu_addr;
        memDIN2  = cpu_wdata;
        memSize  = cpu_size;
        memSign  = cpu_sign;
      end
      WIN_DMA: begin
        dma_gnt  = 1'b1;
        memRDEN2 = ~dma_we;
        memWE2   = dma_we;
        memADDR2 = dma_addr;
        memDIN2  = dma_wdata;
        memSize  = dma_size;
        memSign  = dma_sign;
      end
      default: begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
      end
    endcase
  end

  // Starvation count only grows while the DMA is actually being passed over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((win_s == WIN_DMA) || !dma_req) begin
      starve_cnt_d = '0;
    end else if (win_s == WIN_CPU) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q
                                               : starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    rd_pend_d = {(win_s == WIN_DMA) && !dma_we, (win_s == WIN_CPU) && !cpu_we};
  end

  // Arbitration state.
  always_ff @(posedge clk) begin
    if (RST) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 2'b00;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  // Return data is steered by the owner tag; reset kills an in-flight return.
  always_comb begin
    cpu_rvalid = rd_pend_q[0] & ~RST;
    dma_rvalid = rd_pend_q[1] & ~RST;
    cpu_rdata  = cpu_rvalid ? memDOUT2 : '0;
    dma_rdata  = dma_rvalid ? memDOUT2 : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (STARVE_MAX 4 and 0) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, cpu_sign, dma_req, dma_we, dma_sign;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [1:0]  cpu_size, dma_size;

  logic        o_cpu_gnt [2];
  logic        o_cpu_rv  [2];
  logic [31:0] o_cpu_rd  [2];
  logic        o_dma_gnt [2];
  logic        o_dma_rv  [2];
  logic [31:0] o_dma_rd  [2];
  logic        o_rden    [2];
  logic        o_we      [2];
  logic [31:0] o_addr    [2];
  logic [31:0] o_din     [2];
  logic [1:0]  o_size    [2];
  logic        o_sign    [2];
  logic [31:0] mdout     [2];

  logic [31:0] mem [2][256];
  logic        init_done = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_cnt   [2];
  bit m_pcpu  [2];
  bit m_pdma  [2];
  bit won_cpu [2];
  bit won_dma [2];
  int sm      [2];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut0 (
    .clk(clk), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_gnt(o_cpu_gnt[0]),
    .cpu_rvalid(o_cpu_rv[0]), .cpu_rdata(o_cpu_rd[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_sign(dma_sign), .dma_gnt(o_dma_gnt[0]),
    .dma_rvalid(o_dma_rv[0]), .dma_rdata(o_dma_rd[0]),
    .memRDEN2(o_rden[0]), .memWE2(o_we[0]), .memADDR2(o_addr[0]), .memDIN2(o_din[0]),
    .memSize(o_size[0]), .memSign(o_sign[0]), .memDOUT2(mdout[0])
  );

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(0)) dut1 (
    .clk(clk), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_gnt(o_cpu_gnt[1]),
    .cpu_rvalid(o_cpu_rv[1]), .cpu_rdata(o_cpu_rd[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_sign(dma_sign), .dma_gnt(o_dma_gnt[1]),
    .dma_rvalid(o_dma_rv[1]), .dma_rdata(o_dma_rd[1]),
    .memRDEN2(o_rden[1]), .memWE2(o_we[1]), .memADDR2(o_addr[1]), .memDIN2(o_din[1]),
    .memSize(o_size[1]), .memSign(o_sign[1]), .memDOUT2(mdout[1])
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Synchronous memory per instance; idle cycles return junk to expose ungated rdata.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) mem[k][i] <= init_val(i);
      init_done <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (o_we[k]) mem[k][o_addr[k][9:2]] <= o_din[k];
    end
    for (int k = 0; k < 2; k++)
      mdout[k] <= o_rden[k] ? mem[k][o_addr[k][9:2]] : $urandom;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: decide the winner from the arbitration rules and check every output.
  initial begin
    int w;
    bit e_crv, e_drv;
    sm[0] = 4;
    sm[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pcpu[k] = 0; m_pdma[k] = 0; won_cpu[k] = 0; won_dma[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        w = 0;
        if (!RST) begin
          if (cpu_req && dma_req) w = (m_cnt[k] == sm[k]) ? 2 : 1;
          else if (cpu_req)       w = 1;
          else if (dma_req)       w = 2;
        end
        chk("cpu_gnt", k, 32'(o_cpu_gnt[k]), 32'(w == 1));
        chk("dma_gnt", k, 32'(o_dma_gnt[k]), 32'(w == 2));
        chk("memRDEN2", k, 32'(o_rden[k]),
            32'((w == 1 && !cpu_we) || (w == 2 && !dma_we)));
        chk("memWE2", k, 32'(o_we[k]), 32'((w == 1 && cpu_we) || (w == 2 && dma_we)));
        chk("memADDR2", k, o_addr[k], w == 1 ? cpu_addr : (w == 2 ? dma_addr : 32'h0));
        chk("memDIN2", k, o_din[k], w == 1 ? cpu_wdata : (w == 2 ? dma_wdata : 32'h0));
        chk("memSize", k, 32'(o_size[k]),
            32'(w == 1 ? cpu_size : (w == 2 ? dma_size : 2'b00)));
        chk("memSign", k, 32'(o_sign[k]),
            32'(w == 1 ? cpu_sign : (w == 2 ? dma_sign : 1'b0)));
        e_crv = !RST && m_pcpu[k];
        e_drv = !RST && m_pdma[k];
        chk("cpu_rvalid", k, 32'(o_cpu_rv[k]), 32'(e_crv));
        chk("dma_rvalid", k, 32'(o_dma_rv[k]), 32'(e_drv));
        chk("cpu_rdata", k, o_cpu_rd[k], e_crv ? mdout[k] : 32'h0);
        chk("dma_rdata", k, o_dma_rd[k], e_drv ? mdout[k] : 32'h0);
        if (RST) begin
          m_cnt[k] = 0; m_pcpu[k] = 0; m_pdma[k] = 0;
        end else begin
          m_pcpu[k] = (w == 1) && !cpu_we;
          m_pdma[k] = (w == 2) && !dma_we;
          if (w == 2 || !dma_req) m_cnt[k] = 0;
          else if (w == 1)        m_cnt[k] = (m_cnt[k] + 1 > sm[k]) ? sm[k] : m_cnt[k] + 1;
        end
        won_cpu[k] = (w == 1);
        won_dma[k] = (w == 2);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
  endtask

  // Directed scenarios with hand-computed expectations, then constrained-random traffic.
  initial begin
    logic [11:0] dma_slots;
    bit hold_c, hold_d;
    dma_slots = 12'b0010_0001_0000;
    cpu_size = 2'b10; cpu_sign = 1'b0; dma_size = 2'b10; dma_sign = 1'b0;
    RST = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
    set_dma(1'b1, 1'b0, 32'h200, 32'h0);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_cpu_gnt", 0, 32'(o_cpu_gnt[0]), 32'h0);
      chk("rst_dma_gnt", 0, 32'(o_dma_gnt[0]), 32'h0);
      chk("rst_dma_gnt", 1, 32'(o_dma_gnt[1]), 32'h0);
      next_cycle();
    end
    RST = 1'b0;
    @(negedge clk);
    chk("rel_cpu_gnt", 0, 32'(o_cpu_gnt[0]), 32'h1);
    chk("rel_rden", 0, 32'(o_rden[0]), 32'h1);
    chk("rel_addr", 0, o_addr[0], 32'h100);
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_cpu_rvalid", 0, 32'(o_cpu_rv[0]), 32'h1);
    chk("rd_cpu_rdata", 0, o_cpu_rd[0], 32'hDEAD_BEEF);
    chk("rd_dma_rvalid", 0, 32'(o_dma_rv[0]), 32'h0);

    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
    set_dma(1'b1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("cont_cpu_gnt", 0, 32'(o_cpu_gnt[0]), 32'(!dma_slots[i]));
      chk("cont_dma_gnt", 0, 32'(o_dma_gnt[0]), 32'(dma_slots[i]));
      chk("cont0_dma_gnt", 1, 32'(o_dma_gnt[1]), 32'h1);
      chk("cont0_cpu_gnt", 1, 32'(o_cpu_gnt[1]), 32'h0);
      if (i > 0) begin
        chk("cont_cpu_rv", 0, 32'(o_cpu_rv[0]), 32'(!dma_slots[i-1]));
        chk("cont_dma_rv", 0, 32'(o_dma_rv[0]), 32'(dma_slots[i-1]));
      end
      next_cycle();
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("alone_cpu_gnt", 1, 32'(o_cpu_gnt[1]), 32'h1);
    chk("alone_cpu_gnt", 0, 32'(o_cpu_gnt[0]), 32'h1);

    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("pipe_cpu_rv", k, 32'(o_cpu_rv[k]), 32'h1);
      chk("pipe_cpu_rd", k, o_cpu_rd[k], 32'h1404_0404);
      chk("pipe_dma_gnt", k, 32'(o_dma_gnt[k]), 32'h1);
    end
    next_cycle();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("pipe_dma_rv", k, 32'(o_dma_rv[k]), 32'h1);
      chk("pipe_dma_rd", k, o_dma_rd[k], 32'h1808_0808);
      chk("pipe_cpu_rv2", k, 32'(o_cpu_rv[k]), 32'h0);
    end

    next_cycle();
    set_dma(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    @(negedge clk);
    chk("wr_we", 0, 32'(o_we[0]), 32'h1);
    chk("wr_rden", 0, 32'(o_rden[0]), 32'h0);
    chk("wr_din", 0, o_din[0], 32'hCAFE_F00D);
    next_cycle();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_no_rv", 0, 32'(o_dma_rv[0]), 32'h0);
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("pre_rst_gnt", 0, 32'(o_cpu_gnt[0]), 32'h1);
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    RST = 1'b1;
    @(negedge clk);
    chk("rst_kill_rv", 0, 32'(o_cpu_rv[0]), 32'h0);
    chk("rst_kill_rd", 0, o_cpu_rd[0], 32'h0);
    next_cycle();
    RST = 1'b0;
    @(negedge clk);
    chk("rst_kill_rv2", 0, 32'(o_cpu_rv[0]), 32'h0);
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_readback", 0, o_cpu_rd[0], 32'hCAFE_F00D);

    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      // An ungranted requester must keep its access stable in both instances.
      hold_c = cpu_req && !(won_cpu[0] && won_cpu[1]);
      hold_d = dma_req && !(won_dma[0] && won_dma[1]);
      if (!hold_c) begin
        cpu_req   = ($urandom_range(0, 9) < 6);
        cpu_we    = ($urandom_range(0, 3) == 0);
        cpu_addr  = {22'd0, 8'($urandom), 2'b00};
        cpu_wdata = $urandom;
        cpu_size  = 2'($urandom_range(0, 2));
        cpu_sign  = 1'($urandom);
      end
      if (!hold_d) begin
        dma_req   = ($urandom_range(0, 9) < 6);
        dma_we    = ($urandom_range(0, 3) == 0);
        dma_addr  = {22'd0, 8'($urandom), 2'b00};
        dma_wdata = $urandom;
        dma_size  = 2'($urandom_range(0, 2));
        dma_sign  = 1'($urandom);
      end
      RST = ($urandom_range(0, 49) == 0);
    end
    next_cycle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
